alu_div_sequencer: RTL and testbench

Multi-cycle 8-bit restoring divider that drives the datapath's shared add/sub ALU as an initiator. It presents operands and a subtract opcode to the ALU each iteration, then consumes the ALU's result and less-than flag. It sits beside the ALU in the execute stage. Control issues a one-cycle `Start` and waits for `Done`; the ALU is otherwise free when the sequencer is idle.

---
 rtl/alu_div_sequencer.sv | 111 +++++++++++
 tb/tb_alu_div_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_div_sequencer.sv
// alu_div_sequencer: 8-bit restoring divider that drives the shared add/sub ALU one quotient bit per cycle.
// Optional signed mode is enabled with `define ALU_DIV_SIGNED_EN.
module alu_div_sequencer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] Dividend,
    input  logic [7:0] Divisor,
    output logic       Busy,
    output logic       Done,
    output logic       DivByZero,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic [7:0] AluA,
    output logic [7:0] AluB,
    output logic       AluOP,
    input  logic [7:0] AluOut,
    input  logic       AluZero,
    input  logic       AluLT
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t     state_q;
    logic [7:0] r_q, q_q, d_q, r_d, q_d, t;
    logic [7:0] quo_q, rem_q, a_mag, b_mag, quo_fin, rem_fin;
    logic [2:0] cnt_q;
    logic       busy_q, done_q, dbz_q, in_iter, start_ok;
    logic       unused_alu_zero;
    assign unused_alu_zero = AluZero;
`ifdef ALU_DIV_SIGNED_EN
    logic qneg_q, rneg_q;
`endif
    // Trial subtract on the ALU, restore step, and result/operand conditioning
    always_comb begin
        t        = {r_q[6:0], q_q[7]};
        in_iter  = state_q == ITER;
        start_ok = Start && !in_iter;
        AluA     = in_iter ? t : 8'd0;
        AluB     = in_iter ? d_q : 8'd0;
        AluOP    = in_iter;
        r_d      = AluLT ? t : AluOut;
        q_d      = {q_q[6:0], ~AluLT};
`ifdef ALU_DIV_SIGNED_EN
        a_mag    = Dividend[7] ? -Dividend : Dividend;
        b_mag    = Divisor[7] ? -Divisor : Divisor;
        quo_fin  = qneg_q ? -q_d : q_d;
        rem_fin  = rneg_q ? -r_d : r_d;
`else
        a_mag    = Dividend;
        b_mag    = Divisor;
        quo_fin  = q_d;
        rem_fin  = r_d;
`endif
    end
    // Control FSM with registered status and result outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= 8'd0;
            rem_q   <= 8'd0;
            r_q     <= 8'd0;
            q_q     <= 8'd0;
            d_q     <= 8'd0;
            cnt_q   <= 3'd0;
`ifdef ALU_DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else if (in_iter) begin
            r_q   <= r_d;
            q_q   <= q_d;
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd0) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                quo_q   <= quo_fin;
                rem_q   <= rem_fin;
            end
        end else if (start_ok && Divisor == 8'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            dbz_q   <= 1'b1;
            quo_q   <= 8'hFF;
            rem_q   <= Dividend;
        end else if (start_ok) begin
            state_q <= ITER;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            r_q     <= 8'd0;
            q_q     <= a_mag;
            d_q     <= b_mag;
            cnt_q   <= 3'd7;
`ifdef ALU_DIV_SIGNED_EN
            qneg_q  <= Dividend[7] ^ Divisor[7];
            rneg_q  <= Dividend[7];
`endif
        end else begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end
    end
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Quotient  = quo_q;
    assign Remainder = rem_q;
endmodule

// File: tb/tb_alu_div_sequencer.sv
// tb_alu_div_sequencer: directed-vector bench for alu_div_sequencer with a behavioural add/sub ALU.
module tb_alu_div_sequencer;
    logic       Clk = 0, Reset = 1, Start = 0;
    logic [7:0] Dividend = 0, Divisor = 0;
    logic       Busy, Done, DivByZero, AluOP, AluLT, AluZero;
    logic [7:0] Quotient, Remainder, AluA, AluB, AluOut;
    int checks = 0, errors = 0;
    int cycles, busy_n, bad_op, overlap, done_seen;

    alu_div_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Quotient(Quotient), .Remainder(Remainder),
        .AluA(AluA), .AluB(AluB), .AluOP(AluOP), .AluOut(AluOut), .AluZero(AluZero), .AluLT(AluLT)
    );

    assign AluOut  = AluOP ? AluA - AluB : AluA + AluB;
    assign AluZero = AluOut == 8'd0;
    assign AluLT   = AluA < AluB;

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: start pulse for one cycle, then scramble operands.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        Start = 1; Dividend = a; Divisor = b;
        @(negedge Clk);
        Start = 0; Dividend = 8'h5A; Divisor = 8'h00;
    endtask

    // Called in the cycle after the accepted Start edge; returns at the negedge where Done is seen.
    task automatic wait_done(input int inject_at);
        cycles = 0; busy_n = 0; bad_op = 0; overlap = 0;
        for (int i = 0; i < 20; i++) begin
            cycles++;
            if (Busy) busy_n++;
            if (Busy && AluOP !== 1'b1) bad_op++;
            if (Busy && Done) overlap++;
            if (Done) break;
            Start = cycles == inject_at;
            if (cycles == inject_at) begin Dividend = 8'd9; Divisor = 8'd3; end
            @(negedge Clk);
        end
        Start = 0;
        check("done_seen", {15'd0, Done}, 16'd1);
    endtask

    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er);
        launch(a, b);
        wait_done(0);
        check({tag, "_lat"}, 16'(cycles), 16'd9);
        check({tag, "_busy"}, 16'(busy_n), 16'd8);
        check({tag, "_q"}, {8'd0, Quotient}, {8'd0, eq});
        check({tag, "_r"}, {8'd0, Remainder}, {8'd0, er});
        check({tag, "_dbz"}, {15'd0, DivByZero}, 16'd0);
        check({tag, "_aluop"}, 16'(bad_op + overlap), 16'd0);
        check({tag, "_bus_done"}, {AluA, AluB}, 16'd0);
        @(negedge Clk);
    endtask

    initial begin
        @(negedge Clk); @(negedge Clk);
        Reset = 0;
        check("rst_flags", {13'd0, Busy, Done, DivByZero}, 16'd0);
        check("rst_res", {Quotient, Remainder}, 16'd0);
        check("rst_bus", {AluA, AluB}, 16'd0);
        check("rst_op", {15'd0, AluOP}, 16'd0);

        run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2);
        check("done_pulse", {15'd0, Done}, 16'd0);
        run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0);
        run_div("d5_200", 8'd5, 8'd200, 8'd0, 8'd5);
        run_div("d255_130", 8'd255, 8'd130, 8'd1, 8'd125);

        launch(8'd42, 8'd0);
        wait_done(0);
        check("dz_lat", 16'(cycles), 16'd1);
        check("dz_busy", 16'(busy_n), 16'd0);
        check("dz_q", {8'd0, Quotient}, 16'h00FF);
        check("dz_r", {8'd0, Remainder}, 16'd42);
        check("dz_flag", {15'd0, DivByZero}, 16'd1);
        @(negedge Clk);
        check("dz_idle", {15'd0, Done}, 16'd0);
        check("dz_hold", {7'd0, DivByZero, Quotient}, 16'h01FF);

        launch(8'd100, 8'd7);
        wait_done(3);
        check("mid_lat", 16'(cycles), 16'd9);
        check("mid_q", {8'd0, Quotient}, 16'd14);
        check("mid_r", {8'd0, Remainder}, 16'd2);
        launch(8'd9, 8'd3);
        wait_done(0);
        check("b2b_lat", 16'(cycles), 16'd9);
        check("b2b_busy", 16'(busy_n), 16'd8);
        check("b2b_q", {8'd0, Quotient}, 16'd3);
        check("b2b_r", {8'd0, Remainder}, 16'd0);
        @(negedge Clk);

        launch(8'd100, 8'd7);
        @(negedge Clk); @(negedge Clk); @(negedge Clk);
        Reset = 1;
        @(negedge Clk);
        Reset = 0;
        check("abort_flags", {13'd0, Busy, Done, DivByZero}, 16'd0);
        check("abort_res", {Quotient, Remainder}, 16'd0);
        check("abort_bus", {7'd0, AluOP, AluA}, 16'd0);
        check("abort_busb", {8'd0, AluB}, 16'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (Done || Busy) done_seen++;
            @(negedge Clk);
        end
        check("abort_quiet", 16'(done_seen), 16'd0);
        run_div("d50_5", 8'd50, 8'd5, 8'd10, 8'd0);

        Reset = 1; Start = 1; Divisor = 8'd0; Dividend = 8'd7;
        @(negedge Clk);
        Reset = 0; Start = 0;
        check("rst_wins", {14'd0, Done, DivByZero}, 16'd0);
        @(negedge Clk);

`ifdef ALU_DIV_SIGNED_EN
        run_div("s_m100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE);
        run_div("s_100_m7", 8'd100, 8'hF9, 8'hF2, 8'd2);
        run_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
